mobo_mem_responder: RTL and testbench

MOBO_MEM_RESPONDER -- requirements
Module: mobo_mem_responder

---
 rtl/mobo_mem_responder.sv | 133 +++++++++++++
 tb/tb_mobo_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mobo_mem_responder.sv
// Memory-mapped word responder: latches a CPU command, inserts WAIT_CYCLES wait
// states, performs one read or write on its internal array, then holds ack until req drops.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mobo_mem_responder #(
    parameter int word_width  = `WORD_WIDTH,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] mobo_ctrl,
    input  logic [ADDR_WIDTH-1:0] mobo_addr,
    input  logic [word_width-1:0] mobo_wdata,
    output logic [word_width-1:0] mobo_stat,
    output logic [word_width-1:0] mobo_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_e;
    typedef enum logic [1:0] {CMD_RSVD0, CMD_READ, CMD_WRITE, CMD_RSVD3} cmd_e;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                  state;
    logic [CNT_W-1:0]        cnt;
    cmd_e                    cmd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [word_width-1:0]   wdata_q;
    logic                    ack;
    logic                    busy;
    logic                    err;
    logic                    rd_valid;
    logic [word_width-1:0]   rdata_q;
    logic                    bad;
    logic                    mem_we;
    logic                    unused_ctrl;

    logic [word_width-1:0]   mem [DEPTH];

    assign unused_ctrl = ^mobo_ctrl[word_width-1:3];

    always_comb begin
        bad = ({1'b0, addr_q} >= DEPTH_LIM) || (cmd_q != CMD_READ && cmd_q != CMD_WRITE);
    end

    // Reset on the ACCESS edge must win over the store, so the enable looks at rst directly.
    always_comb begin
        mem_we = (state == ACCESS) && !rst && !bad && (cmd_q == CMD_WRITE);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cmd_q    <= CMD_RSVD0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mobo_ctrl[0]) begin
                        cmd_q   <= cmd_e'(mobo_ctrl[2:1]);
                        addr_q  <= mobo_addr;
                        wdata_q <= mobo_wdata;
                        busy    <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    ack   <= 1'b1;
                    if (bad) begin
                        err      <= 1'b1;
                        rd_valid <= 1'b0;
                        rdata_q  <= '0;
                    end else if (cmd_q == CMD_READ) begin
                        rd_valid <= 1'b1;
                        rdata_q  <= mem[addr_q];
                    end
                end
                DONE: begin
                    if (!mobo_ctrl[0]) begin
                        state    <= IDLE;
                        ack      <= 1'b0;
                        err      <= 1'b0;
                        rd_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mobo_stat    = '0;
        mobo_stat[0] = ack;
        mobo_stat[1] = busy;
        mobo_stat[2] = err;
        mobo_stat[3] = rd_valid;
    end

    assign mobo_rdata = rdata_q;

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Self-checking bench: two responders (2 wait states and 0 wait states, DEPTH=200)
// driven by directed and random transactions against a behavioural memory model.
module tb_mobo_mem_responder;

    localparam int DEPTH = 200;
    localparam int WC0   = 2;
    localparam int WC1   = 0;

    logic clk = 1'b0;
    logic rst;
    logic [1:0][31:0] ctrl;
    logic [1:0][31:0] wdata;
    logic [1:0][7:0]  addr;
    logic [1:0][31:0] stat;
    logic [1:0][31:0] rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mm      [2][256];
    bit          written [2][256];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    mobo_mem_responder #(
        .word_width(32), .ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_CYCLES(WC0)
    ) dut0 (
        .clk(clk), .rst(rst), .mobo_ctrl(ctrl[0]), .mobo_addr(addr[0]),
        .mobo_wdata(wdata[0]), .mobo_stat(stat[0]), .mobo_rdata(rdata[0])
    );

    mobo_mem_responder #(
        .word_width(32), .ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_CYCLES(WC1)
    ) dut1 (
        .clk(clk), .rst(rst), .mobo_ctrl(ctrl[1]), .mobo_addr(addr[1]),
        .mobo_wdata(wdata[1]), .mobo_stat(stat[1]), .mobo_rdata(rdata[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Unused command-word bits are randomised so the responder must ignore them.
    task automatic drive(input int u, input logic req, input logic [1:0] cmd,
                         input logic [7:0] a, input logic [31:0] d);
        logic [31:0] c;
        c      = $urandom;
        c[0]   = req;
        c[2:1] = cmd;
        ctrl[u]  = c;
        addr[u]  = a;
        wdata[u] = d;
    endtask

    // One full handshake; drop_at<0 keeps req high one extra cycle in DONE,
    // otherwise req falls after the drop_at-th busy cycle.
    task automatic txn(input int u, input logic [1:0] cmd, input logic [7:0] a,
                       input logic [31:0] d, input int drop_at, input string tag);
        int          wc;
        bit          bad;
        bit          req;
        logic [31:0] es;
        logic [31:0] er;
        wc  = (u == 0) ? WC0 : WC1;
        bad = (int'(a) >= DEPTH) || (cmd == 2'd0) || (cmd == 2'd3);
        es  = 32'h1 | (bad ? 32'h4 : 32'h0) | ((cmd == 2'd1 && !bad) ? 32'h8 : 32'h0);
        er  = bad ? 32'h0 : ((cmd == 2'd1) ? mm[u][a] : last_rd[u]);
        req = 1'b1;
        drive(u, 1'b1, cmd, a, d);
        for (int i = 0; i <= wc; i++) begin
            @(negedge clk);
            chk({tag, "/busy"}, stat[u], 32'h2);
            if (i == drop_at) req = 1'b0;
            drive(u, req, 2'($urandom), 8'($urandom), $urandom);
        end
        @(negedge clk);
        chk({tag, "/ack_stat"}, stat[u], es);
        chk({tag, "/ack_rdata"}, rdata[u], er);
        if (drop_at < 0) begin
            drive(u, 1'b1, 2'($urandom), 8'($urandom), $urandom);
            @(negedge clk);
            chk({tag, "/hold_stat"}, stat[u], es);
            chk({tag, "/hold_rdata"}, rdata[u], er);
            drive(u, 1'b0, 2'($urandom), 8'($urandom), $urandom);
        end
        @(negedge clk);
        chk({tag, "/idle_stat"}, stat[u], 32'h0);
        chk({tag, "/idle_rdata"}, rdata[u], er);
        if (cmd == 2'd2 && !bad) begin
            mm[u][a]      = d;
            written[u][a] = 1'b1;
        end
        last_rd[u] = er;
    endtask

    initial begin
        int          wc;
        int          r;
        int          drop;
        logic [1:0]  cmd;
        logic [7:0]  a;

        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            drive(u, 1'b0, 2'd0, 8'd0, 32'd0);
            last_rd[u] = 32'h0;
        end
        repeat (2) @(negedge clk);
        chk("reset/stat0", stat[0], 32'h0);
        chk("reset/rdata0", rdata[0], 32'h0);
        chk("reset/stat1", stat[1], 32'h0);
        chk("reset/rdata1", rdata[1], 32'h0);
        rst = 1'b0;
        @(negedge clk);

        txn(0, 2'd2, 8'd5, 32'hDEADBEEF, -1, "wr5");
        txn(0, 2'd1, 8'd5, 32'h0, -1, "rd5");
        txn(0, 2'd1, 8'(DEPTH), 32'h0, -1, "rd_oob");
        txn(0, 2'd3, 8'd5, 32'h0, -1, "rsvd11");
        txn(0, 2'd0, 8'd5, 32'h0, -1, "rsvd00");
        txn(0, 2'd2, 8'(DEPTH), 32'h55AA55AA, -1, "wr_oob");
        txn(0, 2'd1, 8'd5, 32'h0, 0, "rd5_again");
        txn(0, 2'd2, 8'(DEPTH - 1), 32'hCAFE0001, 0, "wr_last");
        txn(0, 2'd1, 8'(DEPTH - 1), 32'h0, 1, "rd_last");
        txn(0, 2'd2, 8'd9, 32'h0BADF00D, 0, "drop_wait");
        txn(0, 2'd1, 8'd9, 32'h0, 2, "drop_access");

        txn(0, 2'd2, 8'd7, 32'h00001234, -1, "wr7");
        drive(0, 1'b1, 2'd2, 8'd7, 32'h0000BEEF);
        for (int i = 0; i <= WC0; i++) begin
            @(negedge clk);
            chk("rst_access/busy", stat[0], 32'h2);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_access/stat0", stat[0], 32'h0);
        chk("rst_access/rdata0", rdata[0], 32'h0);
        chk("rst_access/stat1", stat[1], 32'h0);
        rst = 1'b0;
        drive(0, 1'b0, 2'd0, 8'd0, 32'd0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        txn(0, 2'd1, 8'd7, 32'h0, -1, "rd7_after_rst");
        txn(0, 2'd1, 8'd5, 32'h0, -1, "rd5_after_rst");

        txn(1, 2'd2, 8'd0, 32'hA5A5F00F, 0, "w0_wr0");
        txn(1, 2'd1, 8'd0, 32'h0, 0, "w0_rd0");
        txn(1, 2'd1, 8'(DEPTH + 3), 32'h0, -1, "w0_oob");

        for (int u = 0; u < 2; u++) begin
            wc = (u == 0) ? WC0 : WC1;
            for (int n = 0; n < 40; n++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      cmd = 2'd0;
                else if (r == 1) cmd = 2'd3;
                else if (r < 6)  cmd = 2'd1;
                else             cmd = 2'd2;
                a = 8'($urandom_range(0, DEPTH + 15));
                if (cmd == 2'd1 && int'(a) < DEPTH && !written[u][a]) cmd = 2'd2;
                drop = int'($urandom_range(0, wc + 1)) - 1;
                txn(u, cmd, a, $urandom, drop, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
